// File: rtl/hsi_mse_lib_scheduler_if.sv
// Memory-read and MSE-datapath bus between the library scheduler (master)
// and the pixel/library memories plus MSE unit (slave).
interface hsi_mse_lib_scheduler_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_WIDTH_ACC = 48,
  parameter int LENGTH_BITS    = 10,
  parameter int LIB_ADDR       = 8
);
  logic                      rd_en_o;
  logic [LIB_ADDR-1:0]       rd_lib_idx_o;
  logic [LENGTH_BITS-1:0]    rd_band_o;
  logic [DATA_WIDTH-1:0]     pix_data_i;
  logic [DATA_WIDTH-1:0]     ref_data_i;
  logic                      mse_valid_o;
  logic [DATA_WIDTH-1:0]     mse_pix_o;
  logic [DATA_WIDTH-1:0]     mse_ref_o;
  logic                      mse_last_o;
  logic                      mse_res_valid_i;
  logic [DATA_WIDTH_ACC-1:0] mse_res_i;

  modport master (
    output rd_en_o, rd_lib_idx_o, rd_band_o,
    output mse_valid_o, mse_pix_o, mse_ref_o, mse_last_o,
    input  pix_data_i, ref_data_i, mse_res_valid_i, mse_res_i
  );

  modport slave (
    input  rd_en_o, rd_lib_idx_o, rd_band_o,
    input  mse_valid_o, mse_pix_o, mse_ref_o, mse_last_o,
    output pix_data_i, ref_data_i, mse_res_valid_i, mse_res_i
  );
endinterface

// File: rtl/hsi_mse_lib_scheduler.sv
// Sweeps one pixel against every library entry through the MSE datapath and
// tracks the lowest MSE together with the library index that produced it.
module hsi_mse_lib_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_WIDTH_ACC = 48,
  parameter int LENGTH_BITS    = 10,
  parameter int HSI_BANDS      = 128,
  parameter int LIBRARY_SIZE   = 256,
  parameter int LIB_ADDR       = $clog2(LIBRARY_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [LENGTH_BITS-1:0]    cfg_bands_i,
  input  logic [LIB_ADDR:0]         cfg_lib_size_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [DATA_WIDTH_ACC-1:0] min_mse_o,
  output logic [LIB_ADDR-1:0]       min_idx_o,
  hsi_mse_lib_scheduler_if.master   sched_if
);

  localparam logic [LENGTH_BITS-1:0] BANDS_MAX = LENGTH_BITS'(HSI_BANDS);
  localparam logic [LIB_ADDR:0]      LIB_MAX   = (LIB_ADDR+1)'(LIBRARY_SIZE);
  localparam logic [LENGTH_BITS-1:0] BAND_ONE  = LENGTH_BITS'(1);
  localparam logic [LIB_ADDR:0]      SIZE_ONE  = (LIB_ADDR+1)'(1);
  localparam logic [LIB_ADDR-1:0]    IDX_ONE   = LIB_ADDR'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_RES = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LENGTH_BITS-1:0]    bands_q, bands_d;
  logic [LIB_ADDR:0]         lib_size_q, lib_size_d;
  logic [LIB_ADDR-1:0]       lib_idx_q, lib_idx_d;
  logic [LENGTH_BITS-1:0]    band_q, band_d;
  logic [DATA_WIDTH_ACC-1:0] min_q, min_d;
  logic [LIB_ADDR-1:0]       min_idx_q, min_idx_d;
  logic                      err_q, err_d;
  logic                      vld_p0_q, vld_p0_d;
  logic                      last_p0_q, last_p0_d;

  logic cfg_ok;
  logic accept;
  logic reject;
  logic band_last;
  logic lib_last;
  logic res_hit;
  logic better;

  assign cfg_ok    = (cfg_bands_i != '0) && (cfg_bands_i <= BANDS_MAX) &&
                     (cfg_lib_size_i != '0) && (cfg_lib_size_i <= LIB_MAX);
  assign accept    = (state_q == S_IDLE) && start_i && cfg_ok;
  assign reject    = (state_q == S_IDLE) && start_i && !cfg_ok;
  assign band_last = (band_q == (bands_q - BAND_ONE));
  // Compare one bit wider so a 256-entry sweep ends on index 255 without wrap.
  assign lib_last  = ({1'b0, lib_idx_q} == (lib_size_q - SIZE_ONE));
  assign res_hit   = (state_q == S_WAIT_RES) && sched_if.mse_res_valid_i;
  assign better    = (sched_if.mse_res_i < min_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (accept) state_d = S_STREAM;
      S_STREAM:   if (band_last) state_d = S_WAIT_RES;
      S_WAIT_RES: if (res_hit) state_d = lib_last ? S_DONE : S_STREAM;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bands_d    = bands_q;
    lib_size_d = lib_size_q;
    lib_idx_d  = lib_idx_q;
    band_d     = band_q;
    min_d      = min_q;
    min_idx_d  = min_idx_q;
    err_d      = reject;
    vld_p0_d   = (state_q == S_STREAM);
    last_p0_d  = (state_q == S_STREAM) && band_last;

    if (accept) begin
      bands_d    = cfg_bands_i;
      lib_size_d = cfg_lib_size_i;
      lib_idx_d  = '0;
      band_d     = '0;
      min_d      = '1;
      min_idx_d  = '0;
    end

    if (state_q == S_STREAM) begin
      band_d = band_last ? '0 : band_q + BAND_ONE;
    end

    // Strict compare: an equal MSE later in the sweep keeps the earlier index.
    if (res_hit) begin
      if (better) begin
        min_d     = sched_if.mse_res_i;
        min_idx_d = lib_idx_q;
      end
      if (!lib_last) begin
        lib_idx_d = lib_idx_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bands_q    <= '0;
      lib_size_q <= '0;
      lib_idx_q  <= '0;
      band_q     <= '0;
      min_q      <= '0;
      min_idx_q  <= '0;
      err_q      <= 1'b0;
      vld_p0_q   <= 1'b0;
      last_p0_q  <= 1'b0;
    end else begin
      bands_q    <= bands_d;
      lib_size_q <= lib_size_d;
      lib_idx_q  <= lib_idx_d;
      band_q     <= band_d;
      min_q      <= min_d;
      min_idx_q  <= min_idx_d;
      err_q      <= err_d;
      vld_p0_q   <= vld_p0_d;
      last_p0_q  <= last_p0_d;
    end
  end

  // Stage p0: memory returns read data one cycle after rd_en; valid/last are
  // delayed to match and the sample bus is held at zero between samples.
  always_comb begin
    busy_o                = (state_q != S_IDLE);
    done_o                = (state_q == S_DONE);
    error_o               = err_q;
    min_mse_o             = min_q;
    min_idx_o             = min_idx_q;
    sched_if.rd_en_o      = (state_q == S_STREAM);
    sched_if.rd_lib_idx_o = (state_q == S_STREAM) ? lib_idx_q : '0;
    sched_if.rd_band_o    = (state_q == S_STREAM) ? band_q : '0;
    sched_if.mse_valid_o  = vld_p0_q;
    sched_if.mse_last_o   = last_p0_q;
    sched_if.mse_pix_o    = vld_p0_q ? sched_if.pix_data_i : DATA_WIDTH'(0);
    sched_if.mse_ref_o    = vld_p0_q ? sched_if.ref_data_i : DATA_WIDTH'(0);
  end

endmodule

// File: tb/tb_hsi_mse_lib_scheduler.sv
// Bench for hsi_mse_lib_scheduler: behavioural memory and MSE-unit models,
// a sample scoreboard, a table of sweeps and a few hand-written sequences.
module tb_hsi_mse_lib_scheduler;
  localparam int DW = 16;
  localparam int AW = 48;
  localparam int LB = 10;
  localparam int NB = 128;
  localparam int LS = 256;
  localparam int LA = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [LB-1:0] cfg_bands_i = '0;
  logic [LA:0]   cfg_lib_size_i = '0;
  logic          busy_o, done_o, error_o;
  logic [AW-1:0] min_mse_o;
  logic [LA-1:0] min_idx_o;

  hsi_mse_lib_scheduler_if #(.DATA_WIDTH(DW), .DATA_WIDTH_ACC(AW),
                             .LENGTH_BITS(LB), .LIB_ADDR(LA)) sif ();

  hsi_mse_lib_scheduler #(.DATA_WIDTH(DW), .DATA_WIDTH_ACC(AW), .LENGTH_BITS(LB),
                          .HSI_BANDS(NB), .LIBRARY_SIZE(LS), .LIB_ADDR(LA)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_bands_i(cfg_bands_i),
    .cfg_lib_size_i(cfg_lib_size_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .min_mse_o(min_mse_o), .min_idx_o(min_idx_o),
    .sched_if(sif)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix_f(input logic [LA-1:0] l, input logic [LB-1:0] b);
    int v;
    v = int'(l) * 37 + int'(b) * 11 + 5;
    return DW'(v & 'h3fff);
  endfunction

  function automatic logic [DW-1:0] ref_f(input logic [LA-1:0] l, input logic [LB-1:0] b);
    int v;
    v = (int'(l) * 13) ^ (int'(b) * 29 + 1);
    return DW'(v & 'h3fff);
  endfunction

  // Synchronous-read memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (sif.rd_en_o) begin
      sif.pix_data_i <= pix_f(sif.rd_lib_idx_o, sif.rd_band_o);
      sif.ref_data_i <= ref_f(sif.rd_lib_idx_o, sif.rd_band_o);
    end
  end

  typedef struct packed {
    logic [DW-1:0] pix;
    logic [DW-1:0] rf;
    logic          last;
  } sb_t;

  typedef struct packed {
    logic [LB-1:0]      bands;
    logic [LA:0]        lib;
    logic [3:0]         lat;
    logic               err;
    logic [3:0][AW-1:0] res;
    logic [AW-1:0]      exp_min;
    logic [LA-1:0]      exp_idx;
    logic [15:0]        exp_rd;
  } vec_t;

  sb_t           sb_q[$];
  logic [AW-1:0] res_tbl[LS];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            rd_cnt, pending, lat, vec;
  logic [LB-1:0] cur_bands, exp_band;
  logic [LA-1:0] exp_lib;
  logic          stray;
  vec_t          tbl[9];
  localparam logic [AW-1:0] ONES = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle scoreboard and MSE-unit model, run #1 after each rising edge.
  task automatic monitor();
    sb_t e;
    if (sif.mse_valid_o) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("mse_pix", sif.mse_pix_o, e.pix);
        check("mse_ref", sif.mse_ref_o, e.rf);
        check("mse_last", sif.mse_last_o, e.last);
      end
      if (sif.mse_last_o) pending = lat;
    end
    if (sif.rd_en_o) begin
      rd_cnt++;
      check("rd_addr", {sif.rd_lib_idx_o, sif.rd_band_o}, {exp_lib, exp_band});
      e.pix  = pix_f(exp_lib, exp_band);
      e.rf   = ref_f(exp_lib, exp_band);
      e.last = (exp_band == cur_bands - 1'b1);
      sb_q.push_back(e);
      exp_band = exp_band + 1'b1;
      if (exp_band == cur_bands) begin
        exp_band = '0;
        exp_lib  = exp_lib + 1'b1;
      end
    end
    sif.mse_res_valid_i = 1'b0;
    sif.mse_res_i       = '0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        sif.mse_res_valid_i = 1'b1;
        sif.mse_res_i       = res_tbl[vec];
        vec++;
      end
    end
    if (stray) begin
      sif.mse_res_valid_i = 1'b1;
      sif.mse_res_i       = '0;
      stray = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic do_start(input logic [LB-1:0] b, input logic [LA:0] l, input int lt);
    cur_bands = b; lat = lt; exp_lib = '0; exp_band = '0;
    vec = 0; rd_cnt = 0; pending = 0;
    sb_q.delete();
    cfg_bands_i = b; cfg_lib_size_i = l; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget,
                           input logic [AW-1:0] emin, input logic [LA-1:0] eidx,
                           input int erd);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, got, 1'b1);
    check({tag, "_min_mse"}, min_mse_o, emin);
    check({tag, "_min_idx"}, min_idx_o, eidx);
    check({tag, "_rd_cnt"}, rd_cnt, erd);
    tick();
    check({tag, "_done_pulse"}, {done_o, busy_o}, 2'b00);
  endtask

  function automatic vec_t mk(input int b, input int l, input int lt, input logic er,
                              input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                              input logic [AW-1:0] r2, input logic [AW-1:0] r3,
                              input logic [AW-1:0] emin, input int eidx, input int erd);
    vec_t v;
    v.bands = LB'(b); v.lib = (LA+1)'(l); v.lat = 4'(lt); v.err = er;
    v.res[0] = r0; v.res[1] = r1; v.res[2] = r2; v.res[3] = r3;
    v.exp_min = emin; v.exp_idx = LA'(eidx); v.exp_rd = 16'(erd);
    return v;
  endfunction

  initial begin
    logic [AW-1:0] gmin;
    logic [LA-1:0] gidx;
    logic          found;
    stray = 1'b0; pending = 0; lat = 1; vec = 0; rd_cnt = 0;
    cur_bands = 10'd1; exp_band = '0; exp_lib = '0;
    sif.mse_res_valid_i = 1'b0;
    sif.mse_res_i = '0;

    tbl[0] = mk(4,   3,   2, 1'b0, 100, 50, 75, 0, 50, 1, 12);
    tbl[1] = mk(128, 2,   1, 1'b0, 7, 7, 0, 0, 7, 0, 256);
    tbl[2] = mk(0,   3,   1, 1'b1, 0, 0, 0, 0, 7, 0, 0);
    tbl[3] = mk(4,   257, 1, 1'b1, 0, 0, 0, 0, 7, 0, 0);
    tbl[4] = mk(129, 1,   1, 1'b1, 0, 0, 0, 0, 7, 0, 0);
    tbl[5] = mk(4,   0,   1, 1'b1, 0, 0, 0, 0, 7, 0, 0);
    tbl[6] = mk(3,   4,   4, 1'b0, 90, 20, 20, 5, 5, 3, 12);
    tbl[7] = mk(1,   1,   1, 1'b0, 0, 0, 0, 0, 0, 0, 1);
    tbl[8] = mk(2,   2,   2, 1'b0, ONES, ONES, 0, 0, ONES, 0, 4);

    tick(); tick();
    check("reset_outs", {busy_o, done_o, error_o, sif.rd_en_o, sif.mse_valid_o},
          5'b0);
    check("reset_min", {min_mse_o, min_idx_o}, '0);
    rst = 1'b0;
    tick();

    for (int r = 0; r < 9; r++) begin
      for (int k = 0; k < 4; k++) res_tbl[k] = tbl[r].res[k];
      do_start(tbl[r].bands, tbl[r].lib, int'(tbl[r].lat));
      if (tbl[r].err) begin
        check($sformatf("row%0d_err_pulse", r), {error_o, busy_o}, 2'b10);
        tick();
        check($sformatf("row%0d_err_low", r), error_o, 1'b0);
        tick(); tick();
        check($sformatf("row%0d_busy", r), busy_o, 1'b0);
        check($sformatf("row%0d_rd_cnt", r), rd_cnt, 0);
        check($sformatf("row%0d_min", r), {min_mse_o, min_idx_o},
              {tbl[r].exp_min, tbl[r].exp_idx});
      end else begin
        check($sformatf("row%0d_busy", r), busy_o, 1'b1);
        wait_done($sformatf("row%0d", r), 2000, tbl[r].exp_min, tbl[r].exp_idx,
                  int'(tbl[r].exp_rd));
      end
    end

    // Reset while streaming band 2 of entry 1, then a fresh one-entry sweep.
    res_tbl[0] = 500; res_tbl[1] = 400; res_tbl[2] = 300;
    do_start(10'd4, 9'd3, 2);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sif.rd_en_o && sif.rd_lib_idx_o == 8'd1 && sif.rd_band_o == 10'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rst_point_found", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outs", {busy_o, done_o, error_o, sif.rd_en_o, sif.mse_valid_o,
          sif.mse_last_o}, 6'b0);
    @(posedge clk); #1;
    check("rst_edge_outs", {busy_o, sif.rd_en_o, sif.mse_valid_o, sif.mse_pix_o,
          sif.mse_ref_o}, '0);
    check("rst_edge_min", {min_mse_o, min_idx_o}, '0);
    rst = 1'b0;
    sb_q.delete(); pending = 0;
    tick();
    res_tbl[0] = 9;
    do_start(10'd2, 9'd1, 1);
    wait_done("post_rst", 200, 48'd9, 8'd0, 2);

    // Stray result during STREAM and a start while busy are both ignored.
    res_tbl[0] = 40; res_tbl[1] = 30;
    do_start(10'd3, 9'd2, 1);
    stray = 1'b1;
    tick();
    cfg_bands_i = 10'd1; cfg_lib_size_i = 9'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done("stray", 200, 48'd30, 8'd1, 6);

    // Full 256-entry sweep, one band each, result latency 3.
    for (int i = 0; i < LS; i++) res_tbl[i] = AW'($urandom_range(0, 400));
    gmin = '1; gidx = '0;
    for (int i = 0; i < LS; i++) begin
      if (res_tbl[i] < gmin) begin
        gmin = res_tbl[i];
        gidx = LA'(i);
      end
    end
    do_start(10'd1, 9'd256, 3);
    wait_done("full_lib", 5000, gmin, gidx, 256);
    check("full_lib_wrap", exp_lib, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
